// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register write arbiter: FSM encoding and a
// constant-evaluable ceil(log2) used for index-width defaults.
package reg_write_arbiter_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first asserted req scanning from ptr upward with wrap.
// Purely combinational.
module rr_pick
   import reg_write_arbiter_pkg::*;
#(
   parameter int M  = 4,
   parameter int IW = clog2(M)
) (
   input  logic [M-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   int j;

   // Walk the ring from the far end back to ptr so the nearest request wins last.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      j     = 0;
      for (int k = M - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= M) j = j - M;
         if (req[j]) begin
            valid = 1'b1;
            idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for one shared register with a per-requester burst lock.
// Grant and register write happen in the same cycle; rst forces all write outputs low.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int N  = 8,
   parameter int M  = 4,
   parameter int IW = clog2(M)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [M-1:0]    req,
   input  logic [M-1:0]    lock,
   input  logic [M*N-1:0]  d_in,
   output logic [M-1:0]    ack,
   output logic            reg_ce,
   output logic [N-1:0]    reg_d,
   output logic [IW-1:0]   grant_id,
   output logic            busy
);

   state_e          st_q, st_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   grant_id_q, grant_id_d;

   logic            pick_vld;
   logic [IW-1:0]   pick_idx;
   logic            gnt_vld;
   logic [IW-1:0]   gnt_idx;

   function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
      return (v == IW'(M - 1)) ? '0 : v + IW'(1);
   endfunction

   rr_pick #(.M(M), .IW(IW)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   // While locked only the owner may write; an idle owner blocks everyone else.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = pick_idx;
      if (st_q == ST_LOCKED) begin
         gnt_idx = owner_q;
         gnt_vld = req[owner_q];
      end else begin
         gnt_vld = pick_vld;
      end
      if (rst) gnt_vld = 1'b0;
   end

   always_comb begin
      ack = '0;
      for (int i = 0; i < M; i++) begin
         ack[i] = gnt_vld && (gnt_idx == IW'(i));
      end
   end

   assign reg_ce   = gnt_vld;
   assign reg_d    = gnt_vld ? d_in[int'(gnt_idx)*N +: N] : '0;
   assign grant_id = grant_id_q;
   assign busy     = (st_q == ST_LOCKED);

   // Release follows the owner's lock alone, so it can happen on a no-grant cycle.
   always_comb begin
      st_d       = st_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      grant_id_d = grant_id_q;
      if (gnt_vld) grant_id_d = gnt_idx;
      case (st_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               if (lock[gnt_idx]) begin
                  st_d    = ST_LOCKED;
                  owner_d = gnt_idx;
               end else begin
                  ptr_d = inc_wrap(gnt_idx);
               end
            end
         end
         ST_LOCKED: begin
            if (!lock[owner_q]) begin
               st_d  = ST_IDLE;
               ptr_d = inc_wrap(owner_q);
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q       <= ST_IDLE;
         ptr_q      <= '0;
         owner_q    <= '0;
         grant_id_q <= '0;
      end else begin
         st_q       <= st_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         grant_id_q <= grant_id_d;
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus a randomized run
// against a behavioural model of the arbitration rules and the shared register.
module tb_reg_write_arbiter;

   localparam int N  = 8;
   localparam int M  = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [M-1:0]    req = '0;
   logic [M-1:0]    lock = '0;
   logic [M*N-1:0]  d_in = '0;
   logic [M-1:0]    ack;
   logic            reg_ce;
   logic [N-1:0]    reg_d;
   logic [IW-1:0]   grant_id;
   logic            busy;
   logic [N-1:0]    q = '0;

   int passed = 0;
   int total  = 0;

   // Model state
   bit       m_locked;
   int       m_ptr, m_owner, m_gid;
   logic [N-1:0] m_q;

   reg_write_arbiter #(.N(N), .M(M), .IW(IW)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .lock     (lock),
      .d_in     (d_in),
      .ack      (ack),
      .reg_ce   (reg_ce),
      .reg_d    (reg_d),
      .grant_id (grant_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // The shared register the arbiter drives.
   always @(posedge clk) if (reg_ce) q <= reg_d;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_winner();
      if (rst) return -1;
      if (m_locked) return req[m_owner] ? m_owner : -1;
      for (int k = 0; k < M; k++) begin
         if (req[(m_ptr + k) % M]) return (m_ptr + k) % M;
      end
      return -1;
   endfunction

   task automatic test_reset();
      cyc();
      total++; if (ack !== 4'b0000 || busy !== 1'b0) $display("FAIL rst_out ack=%b busy=%b exp 0000/0", ack, busy); else passed++;
      total++; if (grant_id !== 2'd0) $display("FAIL rst_gid got %0d exp 0", grant_id); else passed++;
      req  = 4'b1111;
      d_in = {8'h44, 8'h33, 8'h22, 8'h11};
      #1;
      total++; if (ack !== 4'b0000 || reg_ce !== 1'b0 || reg_d !== 8'h00) $display("FAIL rst_force ack=%b ce=%b d=%h exp 0", ack, reg_ce, reg_d); else passed++;
      rst = 1'b0;
      #1;
      total++; if (ack !== 4'b0001 || reg_d !== 8'h11) $display("FAIL rst_first ack=%b d=%h exp 0001/11", ack, reg_d); else passed++;
      cyc();
      total++; if (grant_id !== 2'd0 || q !== 8'h11) $display("FAIL rst_first_wr gid=%0d q=%h exp 0/11", grant_id, q); else passed++;
      rst = 1'b1;
      #1;
      total++; if (ack !== 4'b0000 || reg_ce !== 1'b0) $display("FAIL rst_mid ack=%b ce=%b exp 0000/0", ack, reg_ce); else passed++;
      rst = 1'b0;
      #1;
      total++; if (ack !== 4'b0001) $display("FAIL rst_ptr ack=%b exp 0001", ack); else passed++;
      req = 4'b0000;
   endtask

   task automatic test_round_robin();
      logic [3:0] ea [5];
      logic [7:0] eq [5];
      ea = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      eq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      cyc();
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (ack !== ea[i]) $display("FAIL rr_ack%0d got %b exp %b", i, ack, ea[i]); else passed++;
         cyc();
         total++; if (q !== eq[i]) $display("FAIL rr_q%0d got %h exp %h", i, q, eq[i]); else passed++;
      end
      req = 4'b0000;
   endtask

   task automatic test_wrap_sparse();
      cyc();
      req = 4'b0100;
      cyc();
      req = 4'b0101;
      #1;
      total++; if (ack !== 4'b0001) $display("FAIL wrap_first got %b exp 0001", ack); else passed++;
      cyc();
      total++; if (ack !== 4'b0100) $display("FAIL wrap_second got %b exp 0100", ack); else passed++;
      cyc();
      req = 4'b1111;
      #1;
      total++; if (ack !== 4'b1000) $display("FAIL wrap_ptr3 got %b exp 1000", ack); else passed++;
      cyc();
      req = 4'b0000;
   endtask

   task automatic test_lock_burst();
      req = 4'b0001;
      cyc();
      req  = 4'b0111;
      lock = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (ack !== 4'b0010) $display("FAIL lock_ack%0d got %b exp 0010", i, ack); else passed++;
         total++; if (busy !== (i > 0)) $display("FAIL lock_busy%0d got %b exp %b", i, busy, (i > 0)); else passed++;
         cyc();
      end
      req  = 4'b0101;
      lock = 4'b0000;
      #1;
      total++; if (ack !== 4'b0000 || busy !== 1'b1) $display("FAIL lock_drop ack=%b busy=%b exp 0000/1", ack, busy); else passed++;
      total++; if (grant_id !== 2'd1 || q !== 8'h22) $display("FAIL lock_wr gid=%0d q=%h exp 1/22", grant_id, q); else passed++;
      cyc();
      total++; if (ack !== 4'b0100 || busy !== 1'b0) $display("FAIL lock_release ack=%b busy=%b exp 0100/0", ack, busy); else passed++;
      cyc();
      req = 4'b0000;
   endtask

   task automatic test_lock_owner_idle();
      req  = 4'b0100;
      lock = 4'b0100;
      cyc();
      req = 4'b0001;
      for (int i = 0; i < 2; i++) begin
         #1;
         total++; if (ack !== 4'b0000 || reg_ce !== 1'b0 || busy !== 1'b1) $display("FAIL idle_owner%0d ack=%b ce=%b busy=%b exp 0000/0/1", i, ack, reg_ce, busy); else passed++;
         cyc();
      end
      total++; if (q !== 8'h33) $display("FAIL idle_owner_q got %h exp 33", q); else passed++;
      req = 4'b0101;
      #1;
      total++; if (ack !== 4'b0100) $display("FAIL idle_owner_back got %b exp 0100", ack); else passed++;
      cyc();
   endtask

   task automatic test_reset_locked();
      d_in = {8'h44, 8'h5A, 8'h22, 8'h11};
      req  = 4'b0100;
      #1;
      total++; if (ack !== 4'b0100 || busy !== 1'b1) $display("FAIL rl_pre ack=%b busy=%b exp 0100/1", ack, busy); else passed++;
      rst = 1'b1;
      #1;
      total++; if (busy !== 1'b0 || ack !== 4'b0000 || reg_ce !== 1'b0) $display("FAIL rl_async busy=%b ack=%b ce=%b exp 0", busy, ack, reg_ce); else passed++;
      cyc();
      total++; if (q !== 8'h33 || grant_id !== 2'd0) $display("FAIL rl_hold q=%h gid=%0d exp 33/0", q, grant_id); else passed++;
      req  = 4'b0000;
      lock = 4'b0000;
      rst  = 1'b0;
   endtask

   task automatic test_random();
      int w;
      logic [M-1:0] exp_ack;
      logic [N-1:0] exp_d;
      m_locked = 1'b0;
      m_ptr    = 0;
      m_owner  = 0;
      m_gid    = 0;
      m_q      = 8'h33;
      for (int c = 0; c < 400; c++) begin
         cyc();
         req  = M'($urandom_range(0, 15));
         lock = M'($urandom & $urandom);
         d_in = {$urandom};
         #1;
         w       = model_winner();
         exp_ack = (w >= 0) ? M'(1 << w) : '0;
         exp_d   = (w >= 0) ? d_in[w*N +: N] : '0;
         total++; if (ack !== exp_ack || reg_ce !== (w >= 0)) $display("FAIL rnd_ack c=%0d got %b/%b exp %b", c, ack, reg_ce, exp_ack); else passed++;
         total++; if (reg_d !== exp_d) $display("FAIL rnd_d c=%0d got %h exp %h", c, reg_d, exp_d); else passed++;
         total++; if (busy !== m_locked || grant_id !== IW'(m_gid)) $display("FAIL rnd_state c=%0d busy=%b gid=%0d exp %b/%0d", c, busy, grant_id, m_locked, m_gid); else passed++;
         total++; if (q !== m_q) $display("FAIL rnd_q c=%0d got %h exp %h", c, q, m_q); else passed++;
         if (w >= 0) begin
            m_gid = w;
            m_q   = exp_d;
         end
         if (!m_locked) begin
            if (w >= 0) begin
               if (lock[w]) begin
                  m_locked = 1'b1;
                  m_owner  = w;
               end else begin
                  m_ptr = (w + 1) % M;
               end
            end
         end else if (!lock[m_owner]) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % M;
         end
      end
      cyc();
      total++; if (q !== m_q) $display("FAIL rnd_q_final got %h exp %h", q, m_q); else passed++;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_wrap_sparse();
      test_lock_burst();
      test_lock_owner_idle();
      test_reset_locked();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
